// File: rtl/dmem_port_arbiter_if.sv
// ============================================================================
// Module  : dmem_port_arbiter_if
// Desc    : Requester (core/loader) and memory-side signal bundle of the arbiter
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_c;
  logic              we_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] wdata_c;
  logic              gnt_c;
  logic              rvalid_c;
  logic [DATA_W-1:0] rdata_c;

  logic              req_l;
  logic              we_l;
  logic [ADDR_W-1:0] addr_l;
  logic [DATA_W-1:0] wdata_l;
  logic              gnt_l;
  logic              rvalid_l;
  logic [DATA_W-1:0] rdata_l;
  logic              lock_l;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        owner;

  // Environment side: both requesters plus the memory model.
  modport master (
    output req_c, we_c, addr_c, wdata_c,
    output req_l, we_l, addr_l, wdata_l, lock_l,
    output mem_rdata,
    input  gnt_c, rvalid_c, rdata_c,
    input  gnt_l, rvalid_l, rdata_l,
    input  mem_en, mem_we, mem_addr, mem_wdata, owner
  );

  modport slave (
    input  req_c, we_c, addr_c, wdata_c,
    input  req_l, we_l, addr_l, wdata_l, lock_l,
    input  mem_rdata,
    output gnt_c, rvalid_c, rdata_c,
    output gnt_l, rvalid_l, rdata_l,
    output mem_en, mem_we, mem_addr, mem_wdata, owner
  );
endinterface

`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
// ============================================================================
// Module  : dmem_port_arbiter
// Desc    : Round-robin core/loader arbiter for a single-port synchronous dmem
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  wire logic          CLK,
  input  wire logic          RESET,
  dmem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [1:0] C_OWN_NONE = 2'b00;
  localparam logic [1:0] C_OWN_CORE = 2'b01;
  localparam logic [1:0] C_OWN_LDR  = 2'b10;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_own_l;
  logic              r_last_l;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_req_c;
  logic              w_req_l;
  logic              w_take;
  logic              w_pick_l;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state  <= ST_IDLE;
      r_own_l  <= 1'b0;
      r_last_l <= 1'b1;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_own_l  <= w_pick_l;
        r_last_l <= w_pick_l;
        r_we     <= w_pick_l ? bus.we_l    : bus.we_c;
        r_addr   <= w_pick_l ? bus.addr_l  : bus.addr_c;
        r_wdata  <= w_pick_l ? bus.wdata_l : bus.wdata_c;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_pick_l    = 1'b0;
    w_req_c     = bus.req_c & ~bus.lock_l;
    w_req_l     = bus.req_l;

    case (r_state)
      ST_IDLE: begin
        if (w_req_c || w_req_l) begin
          w_take      = 1'b1;
          // On a tie the requester that did not win last time goes first.
          w_pick_l    = w_req_l & (~w_req_c | ~r_last_l);
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: w_state_nxt = r_we ? ST_IDLE : ST_RESP;
      ST_RESP:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decode from registered state only, so reset clears them at once.
  always_comb begin
    bus.mem_en    = (r_state == ST_ACCESS);
    bus.mem_we    = (r_state == ST_ACCESS) & r_we;
    bus.mem_addr  = r_addr;
    bus.mem_wdata = r_wdata;
    bus.gnt_c     = (r_state == ST_ACCESS) & ~r_own_l;
    bus.gnt_l     = (r_state == ST_ACCESS) &  r_own_l;
    bus.rvalid_c  = (r_state == ST_RESP)   & ~r_own_l;
    bus.rvalid_l  = (r_state == ST_RESP)   &  r_own_l;
    bus.rdata_c   = bus.rvalid_c ? bus.mem_rdata : '0;
    bus.rdata_l   = bus.rvalid_l ? bus.mem_rdata : '0;
    if (r_state == ST_IDLE) begin
      bus.owner = C_OWN_NONE;
    end else begin
      bus.owner = r_own_l ? C_OWN_LDR : C_OWN_CORE;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// ============================================================================
// Module  : tb_dmem_port_arbiter
// Desc    : Directed scoreboard bench for dmem_port_arbiter with a small dmem model
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_port_arbiter;

  logic CLK;
  logic RESET;
  int   cyc = 0;

  dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) dif ();

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (dif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Synchronous memory; address 0x10 is preloaded with 0xDEADBEEF.
  logic [31:0] mem [0:255];
  bit          wr  [0:255];
  always @(posedge CLK) begin
    if (dif.mem_en) begin
      if (dif.mem_we) begin
        mem[dif.mem_addr[7:0]] <= dif.mem_wdata;
        wr[dif.mem_addr[7:0]]  <= 1'b1;
      end else begin
        dif.mem_rdata <= wr[dif.mem_addr[7:0]] ? mem[dif.mem_addr[7:0]] :
                         (dif.mem_addr[7:0] == 8'h10) ? 32'hDEADBEEF : 32'h0;
      end
    end
  end

  typedef struct {
    int          cyc;
    bit          rv;
    bit          who;
    logic [31:0] addr;
    bit          we;
    logic [31:0] data;
  } ev_t;

  ev_t sbq[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input bit rv, input bit who,
                      input logic [31:0] a, input bit we, input logic [31:0] d);
    ev_t e;
    e.cyc = c; e.rv = rv; e.who = who; e.addr = a; e.we = we; e.data = d;
    sbq.push_back(e);
  endtask

  task automatic on_event(input bit rv, input bit who);
    ev_t         e;
    logic [1:0]  own;
    if (sbq.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got %s_%s at cycle %0d expected none",
               rv ? "rvalid" : "gnt", who ? "l" : "c", cyc);
      return;
    end
    e   = sbq.pop_front();
    own = who ? 2'b10 : 2'b01;
    chk("event_kind",  {30'd0, rv, who}, {30'd0, e.rv, e.who});
    chk("event_cycle", cyc, e.cyc);
    chk("owner",       {30'd0, dif.owner}, {30'd0, own});
    if (!rv) begin
      chk("mem_en_access", {31'd0, dif.mem_en}, 32'd1);
      chk("mem_we",        {31'd0, dif.mem_we}, {31'd0, e.we});
      chk("mem_addr",      dif.mem_addr, e.addr);
      if (e.we) chk("mem_wdata", dif.mem_wdata, e.data);
    end else begin
      chk("rdata",       who ? dif.rdata_l : dif.rdata_c, e.data);
      chk("mem_en_resp", {31'd0, dif.mem_en}, 32'd0);
    end
  endtask

  // Monitor: every presented gnt/rvalid pops and checks the next expectation.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (dif.gnt_c)    on_event(1'b0, 1'b0);
      if (dif.gnt_l)    on_event(1'b0, 1'b1);
      if (dif.rvalid_c) on_event(1'b1, 1'b0);
      if (dif.rvalid_l) on_event(1'b1, 1'b1);
      if (!dif.rvalid_c) chk("rdata_c_zero", dif.rdata_c, 32'h0);
      if (!dif.rvalid_l) chk("rdata_l_zero", dif.rdata_l, 32'h0);
    end
  end

  task automatic step(input int k);
    repeat (k) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step(2);
    RESET = 1'b0;
    step(1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_en"},   {31'd0, dif.mem_en}, 32'd0);
    chk({tag, "_mem_we"},   {31'd0, dif.mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, dif.mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, dif.mem_wdata, 32'd0);
    chk({tag, "_gnt_rv"},   {28'd0, dif.gnt_c, dif.gnt_l, dif.rvalid_c, dif.rvalid_l}, 32'd0);
    chk({tag, "_owner"},    {30'd0, dif.owner}, 32'd0);
    chk({tag, "_rdata"},    dif.rdata_c | dif.rdata_l, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish by 100000");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    RESET = 1'b1;
    dif.req_c = 1'b0; dif.we_c = 1'b0; dif.addr_c = '0; dif.wdata_c = '0;
    dif.req_l = 1'b0; dif.we_l = 1'b0; dif.addr_l = '0; dif.wdata_l = '0;
    dif.lock_l = 1'b0;
    @(negedge CLK);
    chk_all_zero("reset");
    step(1);
    RESET = 1'b0;
    step(1);

    // Core read of preloaded 0x10.
    n = cyc;
    dif.req_c = 1'b1; dif.we_c = 1'b0; dif.addr_c = 32'h10;
    push(n + 1, 0, 0, 32'h10, 0, 32'h0);
    push(n + 2, 1, 0, 32'h0,  0, 32'hDEADBEEF);
    step(1);
    dif.req_c = 1'b0;
    step(2);

    // Loader write to 0x20, then a core read back.
    n = cyc;
    dif.req_l = 1'b1; dif.we_l = 1'b1; dif.addr_l = 32'h20; dif.wdata_l = 32'h12345678;
    push(n + 1, 0, 1, 32'h20, 1, 32'h12345678);
    step(1);
    dif.req_l = 1'b0;
    step(1);
    @(negedge CLK);
    chk("idle_after_write_owner",  {30'd0, dif.owner}, 32'd0);
    chk("idle_after_write_mem_en", {31'd0, dif.mem_en}, 32'd0);
    n = cyc;
    dif.req_c = 1'b1; dif.we_c = 1'b0; dif.addr_c = 32'h20;
    push(n + 1, 0, 0, 32'h20, 0, 32'h0);
    push(n + 2, 1, 0, 32'h0,  0, 32'h12345678);
    step(1);
    dif.req_c = 1'b0;
    step(2);

    // Both requesters reading continuously after reset: C, L, C, L.
    do_reset();
    n = cyc;
    dif.req_c = 1'b1; dif.we_c = 1'b0; dif.addr_c = 32'h10;
    dif.req_l = 1'b1; dif.we_l = 1'b0; dif.addr_l = 32'h20;
    for (int i = 0; i < 2; i++) begin
      push(n + 1 + 6*i, 0, 0, 32'h10, 0, 32'h0);
      push(n + 2 + 6*i, 1, 0, 32'h0,  0, 32'hDEADBEEF);
      push(n + 4 + 6*i, 0, 1, 32'h20, 0, 32'h0);
      push(n + 5 + 6*i, 1, 1, 32'h0,  0, 32'h12345678);
    end
    step(10);
    dif.req_c = 1'b0; dif.req_l = 1'b0;
    step(3);

    // Loader lock: four loader writes, core held off until lock drops.
    n = cyc;
    dif.lock_l = 1'b1;
    dif.req_c = 1'b1; dif.we_c = 1'b0; dif.addr_c = 32'h48;
    dif.req_l = 1'b1; dif.we_l = 1'b1; dif.addr_l = 32'h40; dif.wdata_l = 32'hA0;
    for (int i = 0; i < 4; i++)
      push(n + 1 + 2*i, 0, 1, 32'h40 + 32'(4*i), 1, 32'hA0 + 32'(i));
    push(n + 9,  0, 0, 32'h48, 0, 32'h0);
    push(n + 10, 1, 0, 32'h0,  0, 32'hA2);
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (i < 3) begin
        dif.addr_l  = 32'h40 + 32'(4*(i+1));
        dif.wdata_l = 32'hA0 + 32'(i+1);
        step(1);
      end else begin
        dif.req_l  = 1'b0;
        dif.lock_l = 1'b0;
      end
    end
    step(2);
    dif.req_c = 1'b0;
    step(3);

    // Lock rises while the core read is in ACCESS; read still completes.
    do_reset();
    n = cyc;
    dif.req_c = 1'b1; dif.we_c = 1'b0; dif.addr_c = 32'h4C;
    dif.req_l = 1'b1; dif.we_l = 1'b1; dif.addr_l = 32'h50; dif.wdata_l = 32'h55;
    push(n + 1, 0, 0, 32'h4C, 0, 32'h0);
    push(n + 2, 1, 0, 32'h0,  0, 32'hA3);
    push(n + 4, 0, 1, 32'h50, 1, 32'h55);
    step(1);
    dif.lock_l = 1'b1;
    step(3);
    dif.req_l = 1'b0; dif.lock_l = 1'b0; dif.req_c = 1'b0;
    step(3);

    // Reset during the ACCESS cycle of a core read voids that access.
    n = cyc;
    dif.req_c = 1'b1; dif.we_c = 1'b0; dif.addr_c = 32'h10;
    step(1);
    RESET = 1'b1;
    @(negedge CLK);
    chk_all_zero("midreset");
    step(1);
    RESET = 1'b0;
    n = cyc;
    push(n + 1, 0, 0, 32'h10, 0, 32'h0);
    push(n + 2, 1, 0, 32'h0,  0, 32'hDEADBEEF);
    step(1);
    dif.req_c = 1'b0;
    step(3);

    for (int i = 0; i < 50 && sbq.size() != 0; i++) step(1);
    chk("scoreboard_drained", sbq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
